// File: rtl/craft_pkg.sv
// Shared CRAFT tables, FSM encoding and nibble-level round helpers.
// Nibble 0 is bits [63:60]; in nib_vec_t terms nibble i is element 15-i.
package craft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } craft_state_e;

  typedef logic [15:0][3:0] nib_vec_t;

  localparam logic [3:0] SBOX [16] = '{
    4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
    4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
  };

  localparam logic [3:0] PN [16] = '{
    4'd15, 4'd12, 4'd13, 4'd14, 4'd10, 4'd9, 4'd8, 4'd11,
    4'd6,  4'd5,  4'd4,  4'd7,  4'd1,  4'd2, 4'd3, 4'd0
  };

  localparam logic [3:0] Q [16] = '{
    4'd12, 4'd10, 4'd15, 4'd5, 4'd14, 4'd8, 4'd9,  4'd2,
    4'd11, 4'd3,  4'd7,  4'd4, 4'd6,  4'd0, 4'd1,  4'd13
  };

  localparam logic [3:0] RC_A [32] = '{
    4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hc, 4'h6, 4'hb,
    4'h5, 4'ha, 4'hd, 4'he, 4'hf, 4'h7, 4'h3, 4'h1,
    4'h8, 4'h4, 4'h2, 4'h9, 4'hc, 4'h6, 4'hb, 4'h5,
    4'ha, 4'hd, 4'he, 4'hf, 4'h7, 4'h3, 4'h1, 4'h8
  };

  localparam logic [2:0] RC_B [32] = '{
    3'h1, 3'h4, 3'h2, 3'h5, 3'h6, 3'h7, 3'h3, 3'h1,
    3'h4, 3'h2, 3'h5, 3'h6, 3'h7, 3'h3, 3'h1, 3'h4,
    3'h2, 3'h5, 3'h6, 3'h7, 3'h3, 3'h1, 3'h4, 3'h2,
    3'h5, 3'h6, 3'h7, 3'h3, 3'h1, 3'h4, 3'h2, 3'h5
  };

  function automatic logic [63:0] pn_perm(input logic [63:0] s);
    nib_vec_t v;
    nib_vec_t r;
    v = s;
    r = '0;
    for (int i = 0; i < 16; i++) r[15-i] = v[15-int'(PN[i])];
    return r;
  endfunction

  function automatic logic [63:0] q_perm(input logic [63:0] s);
    nib_vec_t v;
    nib_vec_t r;
    v = s;
    r = '0;
    for (int i = 0; i < 16; i++) r[15-i] = v[15-int'(Q[i])];
    return r;
  endfunction

  // Rows 2 and 3 pass through; row 0 folds in rows 2,3 and row 1 folds in row 3.
  function automatic logic [63:0] mix_cols(input logic [63:0] s);
    nib_vec_t v;
    nib_vec_t r;
    v = s;
    r = v;
    for (int j = 0; j < 4; j++) begin
      r[15-j] = v[15-j] ^ v[7-j] ^ v[3-j];
      r[11-j] = v[11-j] ^ v[3-j];
    end
    return r;
  endfunction

  function automatic logic [63:0] add_rc(input logic [63:0] s, input logic [4:0] rc);
    nib_vec_t r;
    r = s;
    r[11] = r[11] ^ RC_A[rc];
    r[10] = r[10] ^ {1'b0, RC_B[rc]};
    return r;
  endfunction

endpackage

// File: rtl/craft_sbox.sv
// CRAFT 4-bit S-box; the table is an involution so it also serves decryption.
module craft_sbox
  import craft_pkg::*;
(
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);

  assign y_o = SBOX[x_i];

endmodule

// File: rtl/craft_decrypt.sv
// Iterative CRAFT decryptor: one inverse round per enabled clock edge.
// state   | meaning
// ST_IDLE | waiting for in_valid, in_ready high
// ST_RUN  | inverting rounds rc = NR-1 down to 0
// ST_DONE | pt valid, holding until out_ready
module craft_decrypt
  import craft_pkg::*;
#(
  parameter int NR = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  ct,
  input  logic [127:0] key,
  input  logic [63:0]  tweak,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  pt
);

  localparam logic [4:0] RC_INIT = 5'(NR - 1);

  craft_state_e fsm_q, fsm_d;
  logic [4:0]   rc_q, rc_d;
  logic [63:0]  state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [63:0]  tweak_q, tweak_d;
  logic [63:0]  pt_q, pt_d;

  logic [63:0]  sb_out;
  logic [63:0]  tk;
  logic [63:0]  rnd_in;
  logic [63:0]  rnd_out;

  for (genvar g = 0; g < 16; g++) begin : g_sb
    craft_sbox u_sbox (
      .x_i (state_q[63-4*g -: 4]),
      .y_o (sb_out[63-4*g -: 4])
    );
  end

  always_comb begin
    tk = '0;
    unique case (rc_q[1:0])
      2'd0: tk = key_q[127:64] ^ tweak_q;
      2'd1: tk = key_q[63:0]   ^ tweak_q;
      2'd2: tk = key_q[127:64] ^ q_perm(tweak_q);
      2'd3: tk = key_q[63:0]   ^ q_perm(tweak_q);
      default: tk = '0;
    endcase
  end

  // The last encryption round has no SB/PN, so its inverse skips them too.
  assign rnd_in  = (rc_q == RC_INIT) ? state_q : pn_perm(sb_out);
  assign rnd_out = mix_cols(add_rc(rnd_in ^ tk, rc_q));

  always_comb begin
    fsm_d   = fsm_q;
    rc_d    = rc_q;
    state_d = state_q;
    key_d   = key_q;
    tweak_d = tweak_q;
    pt_d    = pt_q;
    if (CE) begin
      unique case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ct;
            key_d   = key;
            tweak_d = tweak;
            rc_d    = RC_INIT;
            fsm_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          state_d = rnd_out;
          if (rc_q == 5'd0) begin
            pt_d  = rnd_out;
            fsm_d = ST_DONE;
          end else begin
            rc_d = rc_q - 5'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) fsm_d = ST_IDLE;
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fsm_q   <= ST_IDLE;
      rc_q    <= '0;
      state_q <= '0;
      key_q   <= '0;
      tweak_q <= '0;
      pt_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rc_q    <= rc_d;
      state_q <= state_d;
      key_q   <= key_d;
      tweak_q <= tweak_d;
      pt_q    <= pt_d;
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign pt        = pt_q;

endmodule

// File: doc/craft_decrypt.md
CRAFT_DECRYPT -- requirements
Module: craft_decrypt

Interface
REQ-001 SHALL have parameter NR, default 32, giving the number of CRAFT rounds inverted per block.
REQ-002 SHALL have port CLK  in  1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port RST  in  1: reset, asynchronous, active-low.
REQ-004 SHALL have port CE  in  1: clock enable; when low, every flop holds its value.
REQ-005 SHALL have port in_valid  in  1: ct/key/tweak are valid.
REQ-006 SHALL have port in_ready  out  1: core can accept a block.
REQ-007 SHALL have port ct  in  64: ciphertext; nibble 0 = bits [63:60], nibble 15 = bits [3:0].
REQ-008 SHALL have port key  in  128: K0 = key[127:64], K1 = key[63:0].
REQ-009 SHALL have port tweak  in  64: tweak T.
REQ-010 SHALL have port out_valid  out  1: pt is valid.
REQ-011 SHALL have port out_ready  in  1: consumer accepts pt.
REQ-012 SHALL have port pt  out  64: recovered plaintext, registered.

Function
REQ-013 SHALL compute tweakeys TK0=K0^T, TK1=K1^T, TK2=K0^Q(T), TK3=K1^Q(T); round i uses TK[i mod 4].
REQ-014 SHALL apply nibble permutations as out[i]=in[P[i]], with PN=[15,12,13,14,10,9,8,11,6,5,4,7,1,2,3,0] and Q=[12,10,15,5,14,8,9,2,11,3,7,4,6,0,1,13].
REQ-015 SHALL apply MC as out[j]=in[j]^in[8+j]^in[12+j], out[4+j]=in[4+j]^in[12+j], with other nibbles unchanged, for j=0..3.
REQ-016 SHALL apply ARC_i as an XOR of the 4-bit constant a_i into nibble 4 and the 3-bit constant b_i (zero-extended) into nibble 5, where a_i and b_i are the CRAFT round constants of encryption round i.
REQ-017 SHALL use a three-state FSM: IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 SHALL, in IDLE on an edge with CE & in_valid, latch ct into the state, latch key and tweak, set round counter rc=NR-1, and go to RUN.
REQ-019 SHALL, on the first RUN edge (rc=NR-1), set state = MC(ARC_rc(ATK_rc(state))) with no SB and no PN, then decrement rc.
REQ-020 SHALL, on each later RUN edge, set state = MC(ARC_rc(ATK_rc(PN(SB(state))))); when rc=0, it SHALL copy the result to pt and go to DONE.
REQ-021 SHALL take exactly NR enabled RUN edges, so that out_valid rises on the NR-th enabled edge after the accept edge.
REQ-022 SHALL stay in DONE, holding pt stable, while out_ready=0; on CE & out_ready it SHALL go to IDLE, with no new accept in the same cycle.
REQ-023 SHALL ignore in_valid outside IDLE and SHALL keep latched key and tweak unaffected by input changes during RUN.
REQ-024 SHALL, when CE is low in any state, freeze FSM, rc, state and pt without extending the latency counted in enabled edges.
REQ-025 SHALL use rc as a 5-bit down-counter that never wraps below 0.

Reset
REQ-026 SHALL, while RST=0, force FSM=IDLE, rc=0, state=0, key/tweak regs=0, pt=0, out_valid=0 and in_ready=1, independent of CLK and CE.
REQ-027 SHALL, on reset asserted mid-RUN or in DONE, abandon the block; after release, the next accepted block SHALL decrypt correctly.

Structure
REQ-028 SHALL take the S-box table, PN, Q, the 32-entry (a_i,b_i) constant table and the FSM state enum from shared package craft_pkg.
REQ-029 SHALL instantiate the existing craft_sbox 16 times for SB; no other sub-module.

Verification
REQ-030 SHALL check the reset scenario: RST=0 mid-RUN, then released -> in_ready=1, out_valid=0, pt=0.
REQ-031 SHALL check known-answer vectors: ct = craft_encrypt model output for P=0x0123456789abcdef, K=0, T=0 -> pt=0x0123456789abcdef after 32 enabled edges.
REQ-032 SHALL check non-zero key and tweak: 1000 random (P,K,T) encrypted by the C model -> pt matches P for every vector.
REQ-033 SHALL check backpressure: out_ready=0 for 10 cycles in DONE -> pt stable, in_ready=0; out_ready=1 -> IDLE the next cycle.
REQ-034 SHALL check CE gating: CE toggled 50% during RUN -> same pt, and out_valid after exactly 32 CE-high edges.
REQ-035 SHALL check back-to-back blocks: in_valid held high, two blocks -> second accepted the cycle after the first is consumed, both correct.
